// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if -- request/grant bundle between eight requesters and the
// round-robin arbiter.
//   req      [7:0] requester i asserts bit i while it wants the resource
//   done           one-cycle release pulse from the current owner
//   grant    [7:0] registered one-hot grant, zero when nobody owns it
//   grant_id [2:0] binary index of the current (or most recent) owner
//   busy           grant is non-zero
//   timeout        one-cycle pulse on a forced release by the hold limit
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input grant, grant_id, busy, timeout);
  modport slave  (input req, done, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-way round-robin arbiter with hold limit.
//   clk   single clock, rising edge
//   rst   synchronous reset, active high
//   bus   rr_arbiter8_if.slave (req/done in, grant/grant_id/busy/timeout out)
// An owner keeps the grant until it pulses done, drops its req bit, or has
// held for HOLD_MAX cycles (0 = unlimited). Every release leaves at least one
// idle cycle and moves the priority pointer to the slot after the owner.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  rr_arbiter8_if.slave    bus
);

  generate
    if (HOLD_MAX < 0 || HOLD_MAX > 31) begin : g_bad_hold_max
      $error("rr_arbiter8: HOLD_MAX must be in 0..31");
    end
  endgenerate

  // Counter value on the last cycle an owner may keep the grant.
  localparam logic [4:0] HOLD_LAST = 5'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [4:0] r_cnt;
  logic [7:0] r_grant;
  logic [2:0] r_grant_id;
  logic       r_busy;
  logic       r_timeout;

  logic       w_found;
  logic [2:0] w_winner;
  logic       w_own_req;
  logic       w_tmo;

  // First set req bit searching ptr, ptr+1, ... ; 3-bit add wraps 7 -> 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && bus.req[r_ptr + 3'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(i);
      end
    end
  end

  assign w_own_req = bus.req[r_grant_id];

  // Forced release only when nothing else would release this cycle, so a
  // coinciding done (or dropped req) is a normal release without the pulse.
  assign w_tmo = (HOLD_MAX != 0) && (r_cnt == HOLD_LAST) && !bus.done && w_own_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 3'd0;
      r_cnt      <= 5'd0;
      r_grant    <= 8'h00;
      r_grant_id <= 3'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timeout <= 1'b0;
          // done is meaningless without an owner and is not looked at here.
          if (w_found) begin
            r_state    <= OWNED;
            r_grant    <= 8'h01 << w_winner;
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
            r_cnt      <= 5'd0;
          end
        end
        OWNED: begin
          if (bus.done || !w_own_req || w_tmo) begin
            r_state   <= IDLE;
            r_grant   <= 8'h00;
            r_busy    <= 1'b0;
            r_ptr     <= r_grant_id + 3'd1;
            r_timeout <= w_tmo;
          end else begin
            r_cnt     <= r_cnt + 5'd1;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = r_busy;
  assign bus.timeout  = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  logic clk;
  logic rst;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] gid;
    logic       busy;
    logic       tmo;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] gid;
    logic       busy;
    logic       tmo;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  task automatic add(input logic r, input logic [7:0] rq, input logic d,
                     input logic [7:0] g, input logic [2:0] id,
                     input logic b, input logic t, input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.grant = g; v.gid = id; v.busy = b; v.tmo = t; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.grant !== e.grant || bus.grant_id !== e.gid ||
        bus.busy !== e.busy || bus.timeout !== e.tmo) begin
      n_bad++;
      $display("FAIL %s: got grant=%h id=%0d busy=%b tmo=%b, want grant=%h id=%0d busy=%b tmo=%b",
               e.name, bus.grant, bus.grant_id, bus.busy, bus.timeout,
               e.grant, e.gid, e.busy, e.tmo);
    end
    // Structural invariant: at most one grant bit, and grant[grant_id]==busy.
    n_cmp++;
    if ($countones(bus.grant) > 1 || bus.grant[bus.grant_id] !== bus.busy) begin
      n_bad++;
      $display("FAIL invariant_%s: got grant=%h id=%0d busy=%b, want onehot0 and grant[id]==busy",
               e.name, bus.grant, bus.grant_id, bus.busy);
    end
  endtask

  initial begin
    exp_t e;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // Reset overrides everything, then single requester grant/release.
    add(1, 8'hFF, 1, 8'h00, 0, 0, 0, "reset");
    add(0, 8'h01, 0, 8'h01, 0, 1, 0, "first_grant");
    add(0, 8'h01, 1, 8'h00, 0, 0, 0, "done_release");
    add(0, 8'h00, 0, 8'h00, 0, 0, 0, "idle_no_req");
    add(0, 8'h00, 1, 8'h00, 0, 0, 0, "idle_done_ignored");

    // Full rotation with req=FF, done one cycle after each grant.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "rot_reset");
    for (int k = 0; k < 8; k++) begin
      add(0, 8'hFF, 0, 8'h01 << k, 3'(k), 1, 0, $sformatf("rot_grant%0d", k));
      add(0, 8'hFF, 1, 8'h00, 3'(k), 0, 0, $sformatf("rot_gap%0d", k));
    end
    add(0, 8'hFF, 0, 8'h01, 0, 1, 0, "rot_wrap_grant0");
    add(0, 8'hFF, 1, 8'h00, 0, 0, 0, "rot_wrap_gap");

    // Owner 7 released, ptr wraps to 0 so requester 0 beats 7.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "wrap_reset");
    add(0, 8'h80, 0, 8'h80, 7, 1, 0, "wrap_own7");
    add(0, 8'h80, 1, 8'h00, 7, 0, 0, "wrap_rel7");
    add(0, 8'h81, 0, 8'h01, 0, 1, 0, "wrap_pick0");
    add(0, 8'h81, 1, 8'h00, 0, 0, 0, "wrap_rel0");

    // Hold limit 4: four grant cycles, timeout pulse, then next requester.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "hold_reset");
    add(0, 8'h06, 0, 8'h02, 1, 1, 0, "hold_c0");
    add(0, 8'h06, 0, 8'h02, 1, 1, 0, "hold_c1");
    add(0, 8'h06, 0, 8'h02, 1, 1, 0, "hold_c2");
    add(0, 8'h06, 0, 8'h02, 1, 1, 0, "hold_c3");
    add(0, 8'h06, 0, 8'h00, 1, 0, 1, "hold_timeout");
    add(0, 8'h06, 0, 8'h04, 2, 1, 0, "hold_next2");
    add(0, 8'h00, 0, 8'h00, 2, 0, 0, "hold_drop2");

    // done on the limit cycle: normal release, no timeout pulse.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "coin_reset");
    add(0, 8'h02, 0, 8'h02, 1, 1, 0, "coin_c0");
    add(0, 8'h02, 0, 8'h02, 1, 1, 0, "coin_c1");
    add(0, 8'h02, 0, 8'h02, 1, 1, 0, "coin_c2");
    add(0, 8'h02, 0, 8'h02, 1, 1, 0, "coin_c3");
    add(0, 8'h02, 1, 8'h00, 1, 0, 0, "coin_done_no_tmo");

    // Owner 3 drops its req: release, no timeout, ptr moves to 4.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "drop_reset");
    add(0, 8'h08, 0, 8'h08, 3, 1, 0, "drop_own3");
    add(0, 8'h10, 0, 8'h00, 3, 0, 0, "drop_release");
    add(0, 8'h18, 0, 8'h10, 4, 1, 0, "drop_ptr4");
    add(0, 8'h00, 0, 8'h00, 4, 0, 0, "drop_rel4");

    // Grant stays with owner regardless of other requests.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "stick_reset");
    add(0, 8'h01, 0, 8'h01, 0, 1, 0, "stick_own0");
    add(0, 8'hFF, 0, 8'h01, 0, 1, 0, "stick_hold");
    add(0, 8'hFF, 1, 8'h00, 0, 0, 0, "stick_rel");

    // Reset while requester 5 owns: no ptr update, search restarts at 0.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "rmid_reset0");
    add(0, 8'h20, 0, 8'h20, 5, 1, 0, "rmid_own5");
    add(0, 8'h24, 0, 8'h20, 5, 1, 0, "rmid_hold5");
    add(1, 8'h24, 0, 8'h00, 0, 0, 0, "rmid_reset");
    add(0, 8'h24, 0, 8'h04, 2, 1, 0, "rmid_pick2");
    add(0, 8'h00, 0, 8'h00, 2, 0, 0, "rmid_rel2");

    // done in IDLE does not suppress arbitration.
    add(1, 8'h00, 0, 8'h00, 0, 0, 0, "idone_reset");
    add(0, 8'h08, 1, 8'h08, 3, 1, 0, "idone_grant3");
    add(0, 8'h08, 0, 8'h08, 3, 1, 0, "idone_hold3");
    add(0, 8'h00, 0, 8'h00, 3, 0, 0, "idone_rel3");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst      = vecs[i].rst;
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      e.grant = vecs[i].grant; e.gid = vecs[i].gid;
      e.busy  = vecs[i].busy;  e.tmo = vecs[i].tmo;
      e.name  = vecs[i].name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out();
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, max cycles one owner may hold the grant; 0 = no limit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req  input  8  request vector; bit i = requester i (bit 0 = requester 0).
REQ-005 done  input  1  one-cycle pulse from the current owner releasing the resource.
REQ-006 grant  output  8  registered one-hot grant; bit i = requester i; all-zero when no owner.
REQ-007 grant_id  output  3  registered binary index of the current owner; holds last owner when grant=0.
REQ-008 busy  output  1  registered; 1 iff grant is non-zero.
REQ-009 timeout  output  1  registered one-cycle pulse marking a forced release by the hold limit.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and OWNED (one owner).
REQ-011 The block SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-012 In IDLE with req != 0 at an edge, the block SHALL select the first set req bit in search order, move to OWNED, and drive grant=one-hot(winner), grant_id=winner, busy=1 after that edge.
REQ-013 Latency: req sampled at edge N SHALL give grant visible after edge N; req=0 in IDLE SHALL leave all outputs unchanged.
REQ-014 In OWNED, grant SHALL remain constant while the release conditions are false, regardless of other req bits.
REQ-015 Release conditions in OWNED are done=1, req[grant_id]=0, or hold limit reached. Any one of them SHALL move the block to IDLE with grant=0 and busy=0 after the edge.
REQ-016 On every release, the block SHALL set ptr = grant_id+1 modulo 8, so 7 wraps to 0.
REQ-017 After a release, grant SHALL be 0 for at least one cycle; the earliest new grant comes one edge after the release edge.
REQ-018 A 5-bit hold counter SHALL reset to 0 on entry to OWNED and increment each OWNED cycle.
REQ-019 When HOLD_MAX != 0, the counter equals HOLD_MAX-1, and done=0 with req[grant_id]=1, the block SHALL force release with timeout=1 for exactly one cycle.
REQ-020 done and timeout coinciding SHALL count as a normal release with timeout=0.
REQ-021 done=1 in IDLE SHALL be ignored; it neither changes ptr nor suppresses arbitration in that cycle.
REQ-022 grant SHALL never have more than one bit set, and grant[grant_id] SHALL equal busy in every cycle.
REQ-023 HOLD_MAX values above 31 are illegal and SHALL be rejected at elaboration.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, ptr=0, counter=0, grant=8'h00, grant_id=3'd0, busy=0, timeout=0, overriding every other input.
REQ-025 rst asserted mid-ownership SHALL drop grant after that edge without a timeout pulse or a ptr update from the aborted owner.
REQ-026 The first arbitration after reset deassertion SHALL use ptr=0.

Verification
REQ-027 Reset, then req=8'h01 -> after the next edge grant=8'h01, grant_id=0, busy=1; a done pulse -> grant=8'h00 after the following edge.
REQ-028 req=8'hFF held, done pulsed one cycle after each grant -> grant_id sequence 0,1,2,...,7,0 with one grant=0 cycle between owners.
REQ-029 Owner 7 released, then req=8'h81 -> next grant=8'h01 (wrap to requester 0 ahead of 7).
REQ-030 HOLD_MAX=4, req=8'h06, no done -> requester 1 granted for 4 cycles, then grant=0 with timeout=1 for one cycle, then grant=8'h04.
REQ-031 Owner 3 drops req[3] without done -> grant=0 after the edge, ptr=4, timeout=0.
REQ-032 rst pulsed while requester 5 is owner, req=8'h24 held -> grant=0 after the reset edge, then grant=8'h04 (ptr=0 search finds requester 2 first).
